aes_key_schedule_128: RTL and testbench
=======================================

Name: aes_key_schedule_128

Overview:
- AES-128 key-expansion engine.
- Loads a 128-bit cipher key and then produces one 128-bit round key (four 32-bit words) per clock, following the FIPS-197 schedule, for rounds 1..10.
- Feeds the AddRoundKey/round datapath of the iterative AES-128 encryptor. That datapath consumes the words registered on the same cycle it processes each round.
- Contains its own four forward S-box lookups (FIPS-197 table) and the Rcon generator.

Parameters:
none

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset
kld  input  1  key load strobe; sampled on the rising edge
key  input  128  cipher key; key[127:96] is word 0 and key[31:0] is word 3
wo_0  output  32  round-key word 0, registered
wo_1  output  32  round-key word 1, registered
wo_2  output  32  round-key word 2, registered
wo_3  output  32  round-key word 3, registered
round  output  4  index of the round key currently on wo_0..wo_3 (0..10), registered

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at an edge):
  - wo_0..wo_3 <= 0 and round <= 4'hA (idle/saturated).
  - rst has priority over kld.
  - Asserting rst mid-expansion aborts the expansion.
- Load (rst=0, kld=1 at an edge):
  - wo_0 <= key[127:96], wo_1 <= key[95:64], wo_2 <= key[63:32], wo_3 <= key[31:0]; round <= 0.
  - kld during an expansion restarts from the new key. No other handshake is required.
  - If kld is held high, the registers keep reloading the key.
- Expand (rst=0, kld=0, round<10 at an edge):
  - t = SubWord(RotWord(wo_3)) ^ {Rcon[round+1], 24'h0}.
  - RotWord(x) = {x[23:0], x[31:24]}; SubWord applies the S-box to each byte.
  - wo_0' = wo_0 ^ t; wo_1' = wo_1 ^ wo_0'; wo_2' = wo_2 ^ wo_1'; wo_3' = wo_3 ^ wo_2'.
  - round <= round+1.
- Hold (rst=0, kld=0, round==10): all outputs hold. Round 10's key stays stable until the next kld.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (hex). No other index is ever used.
- S-box: the FIPS-197 forward S-box, combinational, 4 instances, all 256 entries exact (e.g. S(00)=63, S(01)=7c, S(53)=ed, S(ff)=16).
- Latency: round key k appears on the outputs k clocks after the load edge. Expansion is exactly one round per clock with no bubbles.
- Outputs change only on clock edges, with no combinational path from inputs to outputs.

Test Plan:
- Reset, then idle with kld=0 for 5 clocks -> wo_0..wo_3 = 0 and round = A throughout.
- kld=1 with key 2b7e151628aed2a6abf7158809cf4f3c for one clock:
  - After the load edge, round=0 and wo = 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - Next edge: round=1, wo = a0fafe17 88542cb1 23a33939 2a6c7605.
  - Next edge: round=2, wo = f2c295f2 7a96b943 5935807a 7359f67f.
- Same key, 10 and then 13 clocks after the load -> wo = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with round=A at both points (hold verified).
- Key all zeros -> round 1 = 62636363 x4; round 2 = 9b9898c9 f9fbfbaa 9b9898c9 f9fbfbaa.
- Restart: load the FIPS key, then at round 4 pulse kld with the zero key -> next outputs are 0s with round=0, followed by 62636363 x4.
- rst and kld both high at the same edge -> outputs 0 and round=A. Reset asserted at round 5 of an expansion -> outputs 0 and round=A on the next edge.

Source files
------------

// File: rtl/aes_key_schedule_128.sv
// AES-128 key-expansion engine: loads a cipher key, then emits one round key per clock
// for rounds 1..10 and holds round 10 until the next load.
module aes_key_schedule_128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  output logic [31:0]  wo_0,
  output logic [31:0]  wo_1,
  output logic [31:0]  wo_2,
  output logic [31:0]  wo_3,
  output logic [3:0]   round
);

  localparam logic [7:0] SBOX_TABLE [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

  // Indexed by the current round, so it yields the constant for the round being produced.
  function automatic logic [7:0] rcon_next(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd0:    c = 8'h01;
      4'd1:    c = 8'h02;
      4'd2:    c = 8'h04;
      4'd3:    c = 8'h08;
      4'd4:    c = 8'h10;
      4'd5:    c = 8'h20;
      4'd6:    c = 8'h40;
      4'd7:    c = 8'h80;
      4'd8:    c = 8'h1b;
      4'd9:    c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  logic [31:0] w0_r, w1_r, w2_r, w3_r;
  logic [3:0]  round_r;
  logic [7:0]  rcon_s;
  logic [31:0] rot_sub_s, t_s, n0_s, n1_s, n2_s, n3_s;

  // Next round key from the current one: RotWord, SubWord, Rcon, then the xor chain
  always_comb begin
    rcon_s    = rcon_next(round_r);
    rot_sub_s = {sbox(w3_r[23:16]), sbox(w3_r[15:8]), sbox(w3_r[7:0]), sbox(w3_r[31:24])};
    t_s       = rot_sub_s ^ {rcon_s, 24'h000000};
    n0_s      = w0_r ^ t_s;
    n1_s      = w1_r ^ n0_s;
    n2_s      = w2_r ^ n1_s;
    n3_s      = w3_r ^ n2_s;
  end

  // Round-key registers: reset beats load, load beats expansion, round 10 is held
  always_ff @(posedge clk) begin
    if (rst) begin
      w0_r    <= 32'h00000000;
      w1_r    <= 32'h00000000;
      w2_r    <= 32'h00000000;
      w3_r    <= 32'h00000000;
      round_r <= 4'hA;
    end else if (kld) begin
      w0_r    <= key[127:96];
      w1_r    <= key[95:64];
      w2_r    <= key[63:32];
      w3_r    <= key[31:0];
      round_r <= 4'd0;
    end else if (round_r < 4'd10) begin
      w0_r    <= n0_s;
      w1_r    <= n1_s;
      w2_r    <= n2_s;
      w3_r    <= n3_s;
      round_r <= round_r + 4'd1;
    end else begin
      w0_r    <= w0_r;
      w1_r    <= w1_r;
      w2_r    <= w2_r;
      w3_r    <= w3_r;
      round_r <= round_r;
    end
  end

  assign wo_0  = w0_r;
  assign wo_1  = w1_r;
  assign wo_2  = w2_r;
  assign wo_3  = w3_r;
  assign round = round_r;

endmodule

// File: tb/tb_aes_key_schedule_128.sv
// Bench for aes_key_schedule_128: FIPS-197 key expansion model built from GF(2^8) arithmetic,
// checked every cycle, plus literal round keys from the FIPS-197 appendix.
module tb_aes_key_schedule_128;

  logic         clk = 1'b0;
  logic         rst, kld;
  logic [127:0] key;
  logic [31:0]  wo_0, wo_1, wo_2, wo_3;
  logic [3:0]   round;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_sbox [0:255];
  logic [31:0] sched  [0:10][0:3];
  logic [31:0] m_w    [0:3];
  logic [3:0]  m_rnd;
  logic        m_valid = 1'b0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_schedule_128 dut (
    .clk(clk), .rst(rst), .kld(kld), .key(key),
    .wo_0(wo_0), .wo_1(wo_1), .wo_2(wo_2), .wo_3(wo_3), .round(round)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box derived from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(a[7:0], b[7:0]) == 8'h01) inv = b[7:0];
      m_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {m_sbox[x[31:24]], m_sbox[x[23:16]], m_sbox[x[15:8]], m_sbox[x[7:0]]};
  endfunction

  // Textbook 44-word expansion, Rcon produced by repeated doubling in GF(2^8).
  task automatic compute_sched(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] temp = w[i-1];
      if (i % 4 == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
        rc   = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++)
      for (int j = 0; j < 4; j++) sched[r][j] = w[4*r + j];
  endtask

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [131:0] dut_out();
    return {round, wo_0, wo_1, wo_2, wo_3};
  endfunction

  // Reference model advanced on every edge, compared shortly after it
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_rnd   = 4'hA;
      for (int j = 0; j < 4; j++) m_w[j] = 32'h0;
    end else if (kld) begin
      m_valid = 1'b1;
      compute_sched(key);
      m_rnd = 4'd0;
      for (int j = 0; j < 4; j++) m_w[j] = sched[0][j];
    end else if (m_rnd < 4'd10) begin
      m_rnd = m_rnd + 4'd1;
      for (int j = 0; j < 4; j++) m_w[j] = sched[m_rnd][j];
    end
    #1;
    if (m_valid) check("model", dut_out(), {m_rnd, m_w[0], m_w[1], m_w[2], m_w[3]});
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst = 1'b1;
    kld = 1'b0;
    key = 128'h0;
    build_sbox();
    check("sbox_00", {124'h0, m_sbox[8'h00]}, 132'h63);
    check("sbox_01", {124'h0, m_sbox[8'h01]}, 132'h7c);
    check("sbox_53", {124'h0, m_sbox[8'h53]}, 132'hed);
    check("sbox_ff", {124'h0, m_sbox[8'hff]}, 132'h16);
    compute_sched(FIPS_KEY);
    check("model_r1", {4'd1, sched[1][0], sched[1][1], sched[1][2], sched[1][3]},
          {4'd1, 128'ha0fafe1788542cb123a339392a6c7605});
    check("model_r10", {4'd10, sched[10][0], sched[10][1], sched[10][2], sched[10][3]},
          {4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("idle", dut_out(), {4'hA, 128'h0});
    end

    kld = 1'b1; key = FIPS_KEY;
    tick(1);
    check("fips_r0", dut_out(), {4'd0, FIPS_KEY});
    kld = 1'b0; key = 128'h0;
    tick(1);
    check("fips_r1", dut_out(), {4'd1, 128'ha0fafe1788542cb123a339392a6c7605});
    tick(1);
    check("fips_r2", dut_out(), {4'd2, 128'hf2c295f27a96b9435935807a7359f67f});
    tick(8);
    check("fips_r10", dut_out(), {4'hA, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    tick(3);
    check("fips_hold", dut_out(), {4'hA, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

    kld = 1'b1; key = 128'h0;
    tick(1);
    kld = 1'b0;
    tick(1);
    check("zero_r1", dut_out(), {4'd1, 128'h62636363626363636263636362636363});
    tick(1);
    check("zero_r2", dut_out(), {4'd2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa});

    kld = 1'b1; key = FIPS_KEY;
    tick(1);
    kld = 1'b0;
    tick(4);
    check("restart_r4", {28'h0, round}, 32'd4);
    kld = 1'b1; key = 128'h0;
    tick(1);
    check("restart_load", dut_out(), {4'd0, 128'h0});
    kld = 1'b0;
    tick(1);
    check("restart_r1", dut_out(), {4'd1, 128'h62636363626363636263636362636363});

    rst = 1'b1; kld = 1'b1; key = FIPS_KEY;
    tick(1);
    check("rst_over_kld", dut_out(), {4'hA, 128'h0});
    rst = 1'b0;
    tick(1);
    kld = 1'b0;
    tick(5);
    check("pre_abort_r5", {28'h0, round}, 32'd5);
    rst = 1'b1;
    tick(1);
    check("abort", dut_out(), {4'hA, 128'h0});
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      kld = ($urandom_range(0, 11) == 0);
      key = {$urandom, $urandom, $urandom, $urandom};
      tick(1);
    end
    rst = 1'b0; kld = 1'b0;
    tick(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
